// File: rtl/audio_mixer.sv
// audio_mixer: N-channel stereo mixer with per-channel 4-bit volume and
// left/right pan. Channels are summed one per clock from a snapshot taken
// at SAMPLE_STB. Each side also drives a first-order sigma-delta bitstream.
module audio_mixer #(
  parameter int NCH = 4,
  parameter int W   = 8,
  parameter int SW  = (NCH > 1) ? W + $clog2(NCH) : W + 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SAMPLE_STB,
  input  logic [NCH*W-1:0] CH_IN,
  input  logic [NCH*4-1:0] VOL,
  input  logic [NCH*2-1:0] PAN,
  output logic             BUSY,
  output logic [SW-1:0]    MIX_L,
  output logic [SW-1:0]    MIX_R,
  output logic             MIX_VALID,
  output logic             OVERRUN,
  output logic             DAC_L,
  output logic             DAC_R
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state_reg, state_next;
  logic [IW-1:0]    idx_reg;
  logic             valid_reg;
  logic             overrun_reg;
  logic [NCH*W-1:0] snap_ch_reg;
  logic [NCH*4-1:0] snap_vol_reg;
  logic [NCH*2-1:0] snap_pan_reg;

  logic             load;
  logic             accum_en;
  logic             finish;
  logic             overrun_set;
  logic             last_idx;
  logic [W-1:0]     cur_smp;
  logic [3:0]       cur_vol;
  logic [W+3:0]     prod;
  logic [W-1:0]     contrib;
  logic [SW-1:0]    contrib_ext;

  // Current channel's contribution: sample * vol / 16, so vol=15 is 15/16 gain.
  // The product never exceeds (2^W-1)*15, so the shifted value fits in W bits.
  assign last_idx    = (idx_reg == IW'(NCH - 1));
  assign cur_smp     = snap_ch_reg[idx_reg*W +: W];
  assign cur_vol     = snap_vol_reg[idx_reg*4 +: 4];
  assign prod        = (W+4)'(cur_smp) * (W+4)'(cur_vol);
  assign contrib     = W'(prod >> 4);
  assign contrib_ext = SW'(contrib);

  // BUSY comes straight from the state register, never from the strobe.
  assign BUSY      = (state_reg != IDLE);
  assign MIX_VALID = valid_reg;
  assign OVERRUN   = overrun_reg;

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state and per-state control strobes; a strobe outside IDLE only flags overrun.
  always_comb begin
    state_next  = state_reg;
    load        = 1'b0;
    accum_en    = 1'b0;
    finish      = 1'b0;
    overrun_set = 1'b0;
    case (state_reg)
      IDLE: begin
        if (SAMPLE_STB) begin
          load       = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        accum_en    = 1'b1;
        overrun_set = SAMPLE_STB;
        if (last_idx) state_next = DONE;
      end
      DONE: begin
        finish      = 1'b1;
        overrun_set = SAMPLE_STB;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Channel index, valid pulse and sticky overrun flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      idx_reg     <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      valid_reg <= finish;
      if (overrun_set) overrun_reg <= 1'b1;
      if (load) idx_reg <= '0;
      else if (accum_en && !last_idx) idx_reg <= idx_reg + IW'(1);
    end
  end

  // Input snapshot so later changes on CH_IN/VOL/PAN cannot disturb a mix.
  always_ff @(posedge CLK) begin
    if (load) begin
      snap_ch_reg  <= CH_IN;
      snap_vol_reg <= VOL;
      snap_pan_reg <= PAN;
    end
  end

  // One accumulator, output register and sigma-delta per side (0 = left, 1 = right).
  for (genvar gi = 0; gi < 2; gi++) begin : g_side
    logic [SW-1:0] acc_reg;
    logic [SW-1:0] mix_reg;
    logic [SW:0]   sd_reg;
    logic          dac_reg;
    logic          route;

    assign route = snap_pan_reg[idx_reg*2 + gi];

    // Accumulate routed contributions, publish on DONE, and run the free-running
    // sigma-delta whose carry out is the registered 1-bit DAC output.
    always_ff @(posedge CLK) begin
      if (RESET) begin
        acc_reg <= '0;
        mix_reg <= '0;
        sd_reg  <= '0;
        dac_reg <= 1'b0;
      end else begin
        if (load) acc_reg <= '0;
        else if (accum_en && route) acc_reg <= acc_reg + contrib_ext;
        if (finish) mix_reg <= acc_reg;
        sd_reg  <= {1'b0, sd_reg[SW-1:0]} + {1'b0, mix_reg};
        dac_reg <= sd_reg[SW];
      end
    end

    if (gi == 0) begin : g_left
      assign MIX_L = mix_reg;
      assign DAC_L = dac_reg;
    end else begin : g_right
      assign MIX_R = mix_reg;
      assign DAC_R = dac_reg;
    end
  end

endmodule

// File: tb/tb_audio_mixer.sv
// tb_audio_mixer: directed checks of audio_mixer (NCH=4, W=8, SW=10) with
// hand-computed expected sums, timing, overrun, reset and sigma-delta density.
module tb_audio_mixer;

  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int SW  = 10;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             SAMPLE_STB;
  logic [NCH*W-1:0] CH_IN;
  logic [NCH*4-1:0] VOL;
  logic [NCH*2-1:0] PAN;
  logic             BUSY;
  logic [SW-1:0]    MIX_L;
  logic [SW-1:0]    MIX_R;
  logic             MIX_VALID;
  logic             OVERRUN;
  logic             DAC_L;
  logic             DAC_R;

  int total = 0;
  int bad   = 0;

  audio_mixer #(.NCH(NCH), .W(W), .SW(SW)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .SAMPLE_STB (SAMPLE_STB),
    .CH_IN      (CH_IN),
    .VOL        (VOL),
    .PAN        (PAN),
    .BUSY       (BUSY),
    .MIX_L      (MIX_L),
    .MIX_R      (MIX_R),
    .MIX_VALID  (MIX_VALID),
    .OVERRUN    (OVERRUN),
    .DAC_L      (DAC_L),
    .DAC_R      (DAC_R)
  );

  // 100 MHz clock; inputs change and outputs are sampled on the falling edge.
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string pre);
    chk({pre, "_busy"},  32'(BUSY),      0);
    chk({pre, "_valid"}, 32'(MIX_VALID), 0);
    chk({pre, "_ovr"},   32'(OVERRUN),   0);
    chk({pre, "_mixl"},  32'(MIX_L),     0);
    chk({pre, "_mixr"},  32'(MIX_R),     0);
    chk({pre, "_dacl"},  32'(DAC_L),     0);
    chk({pre, "_dacr"},  32'(DAC_R),     0);
  endtask

  task automatic drive(input logic [31:0] ch, input logic [15:0] vol, input logic [7:0] pan);
    CH_IN = ch;
    VOL   = vol;
    PAN   = pan;
  endtask

  // Strobe for one cycle; returns at the falling edge just after acceptance (j=0).
  task automatic fire();
    @(negedge CLK);
    SAMPLE_STB = 1'b1;
    @(negedge CLK);
    SAMPLE_STB = 1'b0;
    chk("busy_after_stb", 32'(BUSY), 1);
  endtask

  // Observe cycles j0..12 after acceptance; inputs are scrambled at j=2.
  task automatic watch(input int j0, output int vj, output int nv,
                       output logic [SW-1:0] l, output logic [SW-1:0] r);
    vj = -1;
    nv = 0;
    l  = '0;
    r  = '0;
    for (int j = j0; j <= 12; j++) begin
      @(negedge CLK);
      if (j == 2) begin
        CH_IN = ~CH_IN;
        VOL   = ~VOL;
        PAN   = ~PAN;
      end
      if (MIX_VALID === 1'b1) begin
        nv++;
        if (vj < 0) begin
          vj = j;
          l  = MIX_L;
          r  = MIX_R;
        end
      end
      if (j == NCH)     chk("busy_last_accum", 32'(BUSY), 1);
      if (j == NCH + 1) chk("busy_clear",      32'(BUSY), 0);
    end
  endtask

  task automatic do_mix(input string name, input logic [31:0] ch, input logic [15:0] vol,
                        input logic [7:0] pan, input int exp_l, input int exp_r);
    int vj, nv;
    logic [SW-1:0] l, r;
    drive(ch, vol, pan);
    fire();
    watch(1, vj, nv, l, r);
    chk({name, "_valid_at"}, vj, NCH + 1);
    chk({name, "_nvalid"},   nv, 1);
    chk({name, "_l"},        32'(l), exp_l);
    chk({name, "_r"},        32'(r), exp_r);
  endtask

  initial begin
    int vj, nv, cnt_v, ones_l, ones_r;
    logic [SW-1:0] l, r;

    RESET      = 1'b1;
    SAMPLE_STB = 1'b0;
    drive(32'h0, 16'h0, 8'h0);
    repeat (3) @(negedge CLK);
    check_zero("rst_hold");
    RESET = 1'b0;
    @(negedge CLK);
    check_zero("rst_rel");

    // Single channel at vol 15; other channels loud but muted by vol 0.
    do_mix("single", 32'hFFFF_FFFF, 16'h000F, 8'hFF, 239, 239);
    // Pan: ch0 left, ch1 right, ch2/ch3 both.
    do_mix("pan_sum", 32'hFFFF_FFFF, 16'hFFFF, {2'b11, 2'b11, 2'b10, 2'b01}, 717, 717);
    // Full-scale on every channel, both sides: largest possible sum.
    do_mix("all_both", 32'hFFFF_FFFF, 16'hFFFF, 8'hFF, 956, 956);
    // Mixed volumes: 100*7>>4=43, 200*3>>4=37, 17*1>>4=1, ch3 muted.
    do_mix("mixed_vol", {8'd255, 8'd17, 8'd200, 8'd100}, {4'd0, 4'd1, 4'd3, 4'd7},
           {2'b11, 2'b11, 2'b10, 2'b01}, 44, 38);

    // Back-to-back: a strobe in the MIX_VALID cycle is accepted without overrun.
    drive({8'd0, 8'd0, 8'd200, 8'd0}, {4'd0, 4'd0, 4'd8, 4'd0}, {2'b00, 2'b00, 2'b10, 2'b00});
    fire();
    vj = -1;
    l  = '0;
    r  = '0;
    for (int j = 1; j <= 8; j++) begin
      @(negedge CLK);
      if (MIX_VALID === 1'b1) begin
        vj = j;
        l  = MIX_L;
        r  = MIX_R;
        drive(32'h0A0A_0A0A, 16'hFFFF, 8'h55);
        SAMPLE_STB = 1'b1;
        break;
      end
    end
    chk("b2b_first_valid_at", vj, NCH + 1);
    chk("b2b_first_l", 32'(l), 0);
    chk("b2b_first_r", 32'(r), 100);
    @(negedge CLK);
    SAMPLE_STB = 1'b0;
    chk("b2b_second_busy", 32'(BUSY), 1);
    watch(1, vj, nv, l, r);
    chk("b2b_second_valid_at", vj, NCH + 1);
    chk("b2b_second_nvalid", nv, 1);
    chk("b2b_second_l", 32'(l), 36);
    chk("b2b_second_r", 32'(r), 0);
    chk("b2b_no_overrun", 32'(OVERRUN), 0);

    // Overrun: second strobe two edges after the first is ignored but flagged.
    drive(32'hFFFF_FFFF, 16'hFFFF, 8'h55);
    fire();
    @(negedge CLK);
    chk("ovr_before", 32'(OVERRUN), 0);
    CH_IN      = 32'h0;
    SAMPLE_STB = 1'b1;
    @(negedge CLK);
    SAMPLE_STB = 1'b0;
    @(negedge CLK);
    chk("ovr_set", 32'(OVERRUN), 1);
    watch(4, vj, nv, l, r);
    chk("ovr_valid_at", vj, NCH + 1);
    chk("ovr_nvalid", nv, 1);
    chk("ovr_l", 32'(l), 956);
    chk("ovr_r", 32'(r), 0);
    chk("ovr_sticky", 32'(OVERRUN), 1);

    // Reset during ACCUM: aborts the mix and clears everything, including OVERRUN.
    drive(32'hFFFF_FFFF, 16'hFFFF, 8'hFF);
    fire();
    @(negedge CLK);
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check_zero("rst_mid");
    cnt_v  = 0;
    ones_l = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge CLK);
      if (MIX_VALID !== 1'b0) cnt_v++;
      if (DAC_L !== 1'b0 || DAC_R !== 1'b0) ones_l++;
    end
    chk("rst_mid_no_valid", cnt_v, 0);
    chk("rst_mid_dac_quiet", ones_l, 0);
    chk("rst_mid_mixl", 32'(MIX_L), 0);
    do_mix("post_rst", 32'hFFFF_FFFF, 16'h000F, 8'hFF, 239, 239);

    // Sigma-delta: MIX_L=239+239+34=512, MIX_R=3*239=717; count ones over 1024 cycles.
    do_mix("sd_mix", {8'd255, 8'd68, 8'd255, 8'd255}, {4'd15, 4'd8, 4'd15, 4'd15},
           {2'b10, 2'b01, 2'b11, 2'b11}, 512, 717);
    repeat (4) @(negedge CLK);
    ones_l = 0;
    ones_r = 0;
    for (int j = 0; j < 1024; j++) begin
      @(negedge CLK);
      if (DAC_L === 1'b1) ones_l++;
      if (DAC_R === 1'b1) ones_r++;
    end
    chk("sd_ones_l", ones_l, 512);
    chk("sd_ones_r", ones_r, 717);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
